inst_fifo: RTL and testbench
============================

INST_FIFO -- requirements
Module: inst_fifo

Interface
REQ-001 The block SHALL use one clock and an asynchronous active-high reset, with the ports listed first:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-high
REQ-002 The fetch-side write ports SHALL be:
- write_en_1  in  1  push write_inst_1/write_pc_1
- write_en_2  in  1  push write_inst_2/write_pc_2; honoured only with write_en_1
- write_inst_1, write_inst_2  in  32 each  instruction words
- write_pc_1, write_pc_2  in  32 each  instruction PCs
REQ-003 The issue-side read ports SHALL be:
- read_en_first  in  1  pop one entry (first pipeline issued)
- read_en_second  in  1  pop a second entry; honoured only with read_en_first
REQ-004 The flush port SHALL be: flush  in  1  discard all entries (branch redirect/exception).
REQ-005 The data outputs SHALL be:
- first_inst, first_pc  out  32 each  head entry
- second_inst, second_pc  out  32 each  head+1 entry
REQ-006 The status outputs SHALL be:
- fifo_empty  out  1  count==0
- fifo_one  out  1  count==1
- fifo_full  out  1  free slots <2; fetch must stall
- fifo_count  out  5  occupancy 0..16

Function
REQ-007 Storage SHALL be 16 entries of {inst[31:0], pc[31:0]}, with 4-bit read and write pointers wrapping 15->0 and a 5-bit count.
REQ-008 Outputs SHALL be combinational from the registered state: first_* = head when count>=1, else 0; second_* = head+1 (mod 16) when count>=2, else 0.
REQ-009 A pushed entry SHALL appear on the outputs in the cycle after the write (no write-to-read bypass).
REQ-010 Pops performed SHALL be min(requested pops, count at the start of the cycle); excess pop requests are ignored, and read_en_second alone pops nothing.
REQ-011 Writes accepted SHALL be min(requested writes, 16 - count at the start of the cycle); write_inst_1 takes priority over write_inst_2 and excess writes are dropped.
REQ-012 Pops performed in a cycle SHALL NOT free space for writes in that same cycle.
REQ-013 On a simultaneous read and write, next count SHALL equal count + accepted writes - performed pops; the read pointer advances by pops and the write pointer by accepted writes.
REQ-014 With write_en_1 and write_en_2 both accepted, entry 1 SHALL be stored at wr_ptr and entry 2 at wr_ptr+1 (mod 16).
REQ-015 Flush SHALL take priority over reads and writes in the same cycle: the pointers and count go to 0 next cycle and no write of that cycle is stored.
REQ-016 fifo_full SHALL be asserted when count >= 15.

Reset
REQ-017 While rst is high, the pointers, count and any error flag SHALL be 0. Consequently fifo_empty=1, fifo_one=0, fifo_full=0, fifo_count=0 and all data outputs are 0.
REQ-018 Reset asserted mid-operation SHALL discard all entries immediately, without waiting for a clock edge.
REQ-019 Memory contents SHALL NOT require reset.

Configuration
REQ-020 With macro INST_FIFO_OVERFLOW_CHECK_EN defined, the block SHALL add the output fifo_err (out, 1), a sticky flag. fifo_err sets on any dropped write (REQ-011) or ignored pop (REQ-010), and clears only on rst or flush.
REQ-021 Without INST_FIFO_OVERFLOW_CHECK_EN, the fifo_err port and its logic SHALL be absent, and the remaining behaviour SHALL be unchanged.

Verification
REQ-022 The bench SHALL cover a basic pair: reset; write pair (inst A/pc 0x100, inst B/pc 0x104) -> next cycle first_pc=0x100, second_pc=0x104, count=2, fifo_empty=0, fifo_one=0.
REQ-023 The bench SHALL cover a single pop: from count=2, pulse read_en_first only -> next cycle first_pc=0x104, second_*=0, fifo_one=1.
REQ-024 The bench SHALL cover simultaneous read/write with wrap: fill to 14 entries with wr_ptr near 15; dual-write plus dual-pop for 10 cycles -> count stays 14, PCs are in order across the 15->0 wrap, fifo_full=0.
REQ-025 The bench SHALL cover full and overflow: fill to 15 -> fifo_full=1; dual write -> only entry 1 stored, count=16, fifo_err=1 (macro on).
REQ-026 The bench SHALL cover flush priority: count=5, with flush, dual write and dual pop in the same cycle -> next cycle count=0, fifo_empty=1, fifo_err=0.
REQ-027 The bench SHALL cover an ignored pop: at count=0, assert read_en_first and read_en_second -> count stays 0 and fifo_err=1 (macro on) or no fifo_err port (macro off).

Source files
------------

// File: rtl/inst_fifo.sv
// inst_fifo: 16-entry dual-push/dual-pop instruction FIFO with flush.
// Optional sticky fifo_err output is enabled by defining INST_FIFO_OVERFLOW_CHECK_EN.
module inst_fifo (
    input  logic        clk,
    input  logic        rst,
    input  logic        write_en_1,
    input  logic        write_en_2,
    input  logic [31:0] write_inst_1,
    input  logic [31:0] write_inst_2,
    input  logic [31:0] write_pc_1,
    input  logic [31:0] write_pc_2,
    input  logic        read_en_first,
    input  logic        read_en_second,
    input  logic        flush,
    output logic [31:0] first_inst,
    output logic [31:0] first_pc,
    output logic [31:0] second_inst,
    output logic [31:0] second_pc,
    output logic        fifo_empty,
    output logic        fifo_one,
    output logic        fifo_full,
    output logic [4:0]  fifo_count
`ifdef INST_FIFO_OVERFLOW_CHECK_EN
    ,
    output logic        fifo_err
`endif
);
    logic [63:0] mem_q [16];
    logic [3:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, rd_nxt, wr_nxt;
    logic [4:0]  count_q, count_d, free;
    logic [1:0]  req_rd, req_wr, n_rd, n_wr;

    assign req_rd = read_en_first ? (read_en_second ? 2'd2 : 2'd1) : 2'd0;
    assign req_wr = write_en_1 ? (write_en_2 ? 2'd2 : 2'd1) : 2'd0;
    // Free space is taken from the start-of-cycle count, so same-cycle pops never make room.
    assign free   = 5'd16 - count_q;
    assign n_rd   = (count_q < {3'b0, req_rd}) ? count_q[1:0] : req_rd;
    assign n_wr   = (free < {3'b0, req_wr}) ? free[1:0] : req_wr;
    assign rd_nxt = rd_ptr_q + 4'd1;
    assign wr_nxt = wr_ptr_q + 4'd1;

    always_comb begin
        rd_ptr_d = flush ? 4'd0 : rd_ptr_q + {2'b0, n_rd};
        wr_ptr_d = flush ? 4'd0 : wr_ptr_q + {2'b0, n_wr};
        count_d  = flush ? 5'd0 : count_q + {3'b0, n_wr} - {3'b0, n_rd};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= 4'd0;
            wr_ptr_q <= 4'd0;
            count_q  <= 5'd0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!flush && n_wr != 2'd0) mem_q[wr_ptr_q] <= {write_inst_1, write_pc_1};
        if (!flush && n_wr == 2'd2) mem_q[wr_nxt] <= {write_inst_2, write_pc_2};
    end

    assign {first_inst, first_pc}   = (count_q != 5'd0) ? mem_q[rd_ptr_q] : 64'd0;
    assign {second_inst, second_pc} = (count_q >= 5'd2) ? mem_q[rd_nxt] : 64'd0;
    assign fifo_empty = count_q == 5'd0;
    assign fifo_one   = count_q == 5'd1;
    assign fifo_full  = count_q >= 5'd15;
    assign fifo_count = count_q;

`ifdef INST_FIFO_OVERFLOW_CHECK_EN
    logic err_q, err_d;
    assign err_d = flush ? 1'b0 : err_q | (n_wr != req_wr) | (n_rd != req_rd);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end
    assign fifo_err = err_q;
`endif
endmodule

// File: tb/tb_inst_fifo.sv
// tb_inst_fifo: directed + random checks of inst_fifo against a queue-based model.
module tb_inst_fifo;
    logic        clk = 1'b0, rst = 1'b1;
    logic        write_en_1 = 0, write_en_2 = 0, read_en_first = 0, read_en_second = 0, flush = 0;
    logic [31:0] write_inst_1 = 0, write_inst_2 = 0, write_pc_1 = 0, write_pc_2 = 0;
    logic [31:0] first_inst, first_pc, second_inst, second_pc;
    logic        fifo_empty, fifo_one, fifo_full;
    logic [4:0]  fifo_count;
`ifdef INST_FIFO_OVERFLOW_CHECK_EN
    logic        fifo_err;
`endif

    inst_fifo dut (
        .clk(clk), .rst(rst),
        .write_en_1(write_en_1), .write_en_2(write_en_2),
        .write_inst_1(write_inst_1), .write_inst_2(write_inst_2),
        .write_pc_1(write_pc_1), .write_pc_2(write_pc_2),
        .read_en_first(read_en_first), .read_en_second(read_en_second),
        .flush(flush),
        .first_inst(first_inst), .first_pc(first_pc),
        .second_inst(second_inst), .second_pc(second_pc),
        .fifo_empty(fifo_empty), .fifo_one(fifo_one), .fifo_full(fifo_full),
        .fifo_count(fifo_count)
`ifdef INST_FIFO_OVERFLOW_CHECK_EN
        , .fifo_err(fifo_err)
`endif
    );

    always #5 clk = ~clk;

    logic [63:0] q[$];
    logic        m_err = 1'b0;
    logic [31:0] pc_n = 32'h100;
    int          n_vec = 0, n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int sz = q.size();
        chk("count", 64'(fifo_count), 64'(sz));
        chk("empty", 64'(fifo_empty), 64'(sz == 0));
        chk("one",   64'(fifo_one),   64'(sz == 1));
        chk("full",  64'(fifo_full),  64'(sz >= 15));
        chk("first",  {first_inst, first_pc},   sz >= 1 ? q[0] : 64'd0);
        chk("second", {second_inst, second_pc}, sz >= 2 ? q[1] : 64'd0);
`ifdef INST_FIFO_OVERFLOW_CHECK_EN
        chk("err", 64'(fifo_err), 64'(m_err));
`endif
    endtask

    task automatic step(input logic we1, input logic we2, input logic re1, input logic re2, input logic fl);
        int req_w, req_r, nw, nr, sz;
        write_en_1 = we1; write_en_2 = we2; read_en_first = re1; read_en_second = re2; flush = fl;
        write_inst_1 = $urandom; write_inst_2 = $urandom;
        write_pc_1 = pc_n; write_pc_2 = pc_n + 32'd4; pc_n += 32'd8;
        req_w = we1 ? (we2 ? 2 : 1) : 0;
        req_r = re1 ? (re2 ? 2 : 1) : 0;
        sz = q.size();
        nr = req_r < sz ? req_r : sz;
        nw = req_w < 16 - sz ? req_w : 16 - sz;
        if (fl) begin
            q.delete();
            m_err = 1'b0;
        end else begin
            if (nw < req_w || nr < req_r) m_err = 1'b1;
            repeat (nr) void'(q.pop_front());
            if (nw >= 1) q.push_back({write_inst_1, write_pc_1});
            if (nw >= 2) q.push_back({write_inst_2, write_pc_2});
        end
        @(posedge clk);
        #1 check_all();
    endtask

    initial begin
        #12 check_all();
        @(negedge clk) rst = 1'b0;
        #1 check_all();
        // basic pair
        write_en_1 = 1;
        pc_n = 32'h100;
        step(1, 1, 0, 0, 0);
        chk("pair_first_pc", 64'(first_pc), 64'h100);
        chk("pair_second_pc", 64'(second_pc), 64'h104);
        // single pop
        step(0, 0, 1, 0, 0);
        chk("pop_first_pc", 64'(first_pc), 64'h104);
        chk("pop_second", {second_inst, second_pc}, 64'd0);
        // async reset mid-operation, no clock edge needed
        step(1, 1, 0, 0, 0);
        #2 rst = 1'b1;
        q.delete(); m_err = 1'b0;
        #1 check_all();
        @(negedge clk) rst = 1'b0;
        // fill to 14 with wr_ptr=14, then steady dual push/pop across the wrap
        repeat (7) step(1, 1, 0, 0, 0);
        repeat (10) step(1, 1, 1, 1, 0);
        chk("wrap_count", 64'(fifo_count), 64'd14);
        // full and overflow
        step(1, 0, 0, 0, 0);
        chk("full15", 64'(fifo_full), 64'd1);
        step(1, 1, 0, 0, 0);
        chk("count16", 64'(fifo_count), 64'd16);
        repeat (5) step(0, 0, 1, 1, 0);
        step(0, 0, 1, 0, 0);
        chk("count5", 64'(fifo_count), 64'd5);
        // flush beats simultaneous writes and pops
        step(1, 1, 1, 1, 1);
        chk("flush_empty", 64'(fifo_empty), 64'd1);
        // ignored pop on empty
        step(0, 0, 1, 1, 0);
        // second read enable alone pops nothing
        step(1, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 1, 0, 0, 0);
        // random traffic, biased toward writes to reach full
        repeat (400) step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                          $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                          $urandom_range(0, 24) == 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
